// File: rtl/seg7_scan_pkg.sv
// Shared segment codes and page encodings for the multiplexed seven-segment scanner.
// All segment patterns are active-low: bit0=a ... bit6=g, bit7=dp.
package seg7_scan_pkg;

    typedef enum logic [1:0] {
        PG_HH = 2'd0,
        PG_MM = 2'd1,
        PG_SS = 2'd2
    } page_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_H     = 8'h89;
    localparam logic [7:0] SEG_N     = 8'hAB;
    localparam logic [7:0] SEG_S     = 8'h92;

    function automatic page_e next_page(input page_e pg);
        case (pg)
            PG_HH:   return PG_MM;
            PG_MM:   return PG_SS;
            default: return PG_HH;
        endcase
    endfunction

    function automatic logic [7:0] page_letter(input page_e pg);
        case (pg)
            PG_HH:   return SEG_H;
            PG_MM:   return SEG_N;
            default: return SEG_S;
        endcase
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD nibble to active-low seven-segment pattern; dp always off, 10-15 show a dash.
module seg7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_nib)
            4'd0:    o_seg = 8'hC0;
            4'd1:    o_seg = 8'hF9;
            4'd2:    o_seg = 8'hA4;
            4'd3:    o_seg = 8'hB0;
            4'd4:    o_seg = 8'h99;
            4'd5:    o_seg = 8'h92;
            4'd6:    o_seg = 8'h82;
            4'd7:    o_seg = 8'hF8;
            4'd8:    o_seg = 8'h80;
            4'd9:    o_seg = 8'h90;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Three-digit multiplexed display driver: one page (letter + two BCD digits) per
// frame, with per-frame field snapshots and button/auto page advance.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int CLK_HZ      = 12_000_000,
    parameter int SLOT_HZ     = 1000,
    parameter int BLANK_CYC   = 64,
    parameter int PAGE_FRAMES = 0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_hh,
    input  logic [7:0] i_mm,
    input  logic [7:0] i_ss,
    input  logic       i_pm,
    input  logic       i_next,
    output logic [7:0] o_seg,
    output logic [2:0] o_en
);

    localparam int DIV = CLK_HZ / SLOT_HZ;
    localparam int CW  = $clog2(DIV);
    localparam int FW  = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    page_e         page_q, page_d;
    logic [7:0]    snap_q, snap_d;
    logic          pm_q, pm_d;
    logic          pend_q, pend_d;
    logic [FW-1:0] frm_q, frm_d;
    logic [7:0]    seg_q, seg_d;
    logic [2:0]    en_q, en_d;

    logic          slot_end, frame_end, auto_req, adv;
    logic [3:0]    nib;
    logic [7:0]    dec_seg;

    always_comb begin
        slot_end  = (cnt_q == CW'(DIV - 1));
        frame_end = slot_end && (dig_q == 2'd0);
        auto_req  = (PAGE_FRAMES != 0) && (32'(frm_q) == PAGE_FRAMES - 1);
        adv       = frame_end && (pend_q || auto_req);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        dig_d = dig_q;
        if (slot_end)
            dig_d = (dig_q == 2'd0) ? 2'd2 : dig_q - 2'd1;

        page_d = adv ? next_page(page_q) : page_q;

        snap_d = snap_q;
        pm_d   = pm_q;
        if (frame_end) begin
            case (page_d)
                PG_HH:   snap_d = i_hh;
                PG_MM:   snap_d = i_mm;
                default: snap_d = i_ss;
            endcase
            pm_d = (page_d == PG_HH) && i_pm;
        end

        // A pulse coinciding with the boundary survives the clear and serves the next frame.
        pend_d = (pend_q && !frame_end) || i_next;

        frm_d = frm_q;
        if (frame_end) begin
            if (adv || PAGE_FRAMES == 0)
                frm_d = '0;
            else
                frm_d = frm_q + 1'b1;
        end
    end

    assign nib = (dig_d == 2'd1) ? snap_d[7:4] : snap_d[3:0];

    seg7_decode u_dec (
        .i_nib (nib),
        .o_seg (dec_seg)
    );

    // Outputs are computed from next-state so the registers line up with cnt_q.
    always_comb begin
        en_d  = 3'b111;
        seg_d = SEG_BLANK;
        if (cnt_d >= CW'(BLANK_CYC)) begin
            case (dig_d)
                2'd2: begin
                    en_d  = 3'b011;
                    seg_d = page_letter(page_d);
                end
                2'd1: begin
                    en_d  = 3'b101;
                    seg_d = (page_d == PG_HH && snap_d[7:4] == 4'd0) ? SEG_BLANK : dec_seg;
                end
                default: begin
                    en_d  = 3'b110;
                    seg_d = {~((page_d == PG_HH) && pm_d), dec_seg[6:0]};
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q  <= '0;
            dig_q  <= 2'd2;
            page_q <= PG_HH;
            snap_q <= '0;
            pm_q   <= 1'b0;
            pend_q <= 1'b0;
            frm_q  <= '0;
            seg_q  <= SEG_BLANK;
            en_q   <= 3'b111;
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            page_q <= page_d;
            snap_q <= snap_d;
            pm_q   <= pm_d;
            pend_q <= pend_d;
            frm_q  <= frm_d;
            seg_q  <= seg_d;
            en_q   <= en_d;
        end
    end

    assign o_seg = seg_q;
    assign o_en  = en_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: a frame-level reference model pushes the expected
// display per cycle, a negedge monitor pops and compares for two DUT configurations.
module tb_seg7_scan;

    localparam int DIV   = 12;
    localparam int BLANK = 2;
    localparam int FR    = 3 * DIV;
    localparam int PF[2] = '{0, 2};
    localparam logic [7:0] DEC[16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};
    localparam logic [7:0] LET[3] = '{8'h89, 8'hAB, 8'h92};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] hh = 8'h07, mm = 8'h59, ss = 8'h3C;
    logic       pm = 1'b1, nxt = 1'b0;
    logic [7:0] seg0, seg1;
    logic [2:0] en0, en1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg7_scan #(.CLK_HZ(1200), .SLOT_HZ(100), .BLANK_CYC(BLANK), .PAGE_FRAMES(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_hh(hh), .i_mm(mm), .i_ss(ss), .i_pm(pm),
        .i_next(nxt), .o_seg(seg0), .o_en(en0));

    seg7_scan #(.CLK_HZ(1200), .SLOT_HZ(100), .BLANK_CYC(BLANK), .PAGE_FRAMES(2)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_hh(hh), .i_mm(mm), .i_ss(ss), .i_pm(pm),
        .i_next(nxt), .o_seg(seg1), .o_en(en1));

    // Reference model: time since reset release, page, frames since last advance.
    int         mk[2], mpage[2], mfs[2];
    logic [7:0] msnap[2];
    bit         mpm[2], mpend[2];
    logic [10:0] q0[$], q1[$];

    function automatic logic [10:0] exp_out(int kk, int pg, logic [7:0] sn, bit p);
        int c = kk % DIV;
        int dg = 2 - (kk / DIV) % 3;
        logic [7:0] s;
        logic [2:0] e;
        if (c < BLANK) return {3'b111, 8'hFF};
        e = 3'b111;
        e[dg] = 1'b0;
        if (dg == 2)
            s = LET[pg];
        else if (dg == 1)
            s = (pg == 0 && sn[7:4] == 4'd0) ? 8'hFF : DEC[sn[7:4]];
        else begin
            s = DEC[sn[3:0]];
            if (pg == 0 && p) s[7] = 1'b0;
        end
        return {e, s};
    endfunction

    task automatic model_edge(input int i);
        logic [10:0] ex;
        if (rst) begin
            mk[i] = 0; mpage[i] = 0; mfs[i] = 0; msnap[i] = 8'h00; mpm[i] = 0; mpend[i] = 0;
        end else begin
            if (mk[i] % FR == FR - 1) begin
                mfs[i]++;
                if (mpend[i] || (PF[i] != 0 && mfs[i] == PF[i])) begin
                    mpage[i] = (mpage[i] + 1) % 3;
                    mfs[i] = 0;
                end
                msnap[i] = (mpage[i] == 0) ? hh : (mpage[i] == 1) ? mm : ss;
                mpm[i]   = (mpage[i] == 0) && pm;
                mpend[i] = nxt;
            end else begin
                mpend[i] = mpend[i] || nxt;
            end
            mk[i]++;
        end
        ex = exp_out(mk[i], mpage[i], msnap[i], mpm[i]);
        if (i == 0) q0.push_back(ex); else q1.push_back(ex);
    endtask

    always @(posedge clk) begin
        model_edge(0);
        model_edge(1);
    end

    task automatic cmp(input string name, input logic [10:0] act, input logic [10:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got en=%b seg=%h, expected en=%b seg=%h",
                     name, $time, act[10:8], act[7:0], req[10:8], req[7:0]);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) cmp("dut0_display", {en0, seg0}, q0.pop_front());
        if (q1.size() > 0) cmp("dut1_display", {en1, seg1}, q1.pop_front());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse();
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
    endtask

    // Advance until the model's frame position equals pos (sampled just after the edge).
    task automatic wait_pos(input int pos);
        int t = 0;
        while (mk[0] % FR != pos && t < 2 * FR) begin
            tick();
            t++;
        end
        n_cmp++;
        if (mk[0] % FR != pos) begin
            n_bad++;
            $display("FAIL wait_pos: frame position %0d, expected %0d", mk[0] % FR, pos);
        end
    endtask

    initial begin
        run(3);
        #2 rst = 1'b0;
        run(3 * FR);

        // Pulse mid-frame: advance waits for the boundary.
        wait_pos(15);
        pulse();
        run(2 * FR);

        // Two pulses in one frame advance once.
        wait_pos(5);
        pulse();
        run(6);
        pulse();
        run(2 * FR);

        // Pulse landing in the boundary cycle is held for the next frame.
        wait_pos(FR - 1);
        pulse();
        run(3 * FR);

        // Invalid nibble, then a mid-frame change that must not tear.
        ss = 8'h3C;
        wait_pos(10);
        ss = 8'h41;
        run(3 * FR);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (i % 40 == 0) begin
                hh = 8'($urandom);
                mm = 8'($urandom);
                ss = 8'($urandom);
                pm = 1'($urandom);
            end
            nxt = (!nxt && $urandom_range(0, 19) == 0);
            tick();
        end
        nxt = 1'b0;
        run(FR);

        // Asynchronous reset at cnt=7 of dig=1 blanks immediately.
        hh = 8'h12; pm = 1'b1;
        wait_pos(DIV + 7);
        #2 rst = 1'b1;
        q0.delete(); q1.delete();
        q0.push_back({3'b111, 8'hFF});
        q1.push_back({3'b111, 8'hFF});
        #1;
        cmp("async_reset_dut0", {en0, seg0}, {3'b111, 8'hFF});
        cmp("async_reset_dut1", {en1, seg1}, {3'b111, 8'hFF});
        run(2);
        #2 rst = 1'b0;
        run(3 * FR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
